// File: rtl/enigma_seq_ctrl.sv
// Enigma sequencer: rotor stepping (notch + double step) and seven-pass
// time-multiplexing of a shared substitution datapath, valid/ready on both sides.
module enigma_seq_ctrl #(
  parameter int unsigned NOTCH_R = 21,
  parameter int unsigned NOTCH_M = 4,
  parameter int unsigned NOTCH_L = 16,
  parameter int unsigned ALPHA   = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_load,
  input  logic [4:0] cfg_pos_l,
  input  logic [4:0] cfg_pos_m,
  input  logic [4:0] cfg_pos_r,
  input  logic       in_valid,
  input  logic [4:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [4:0] out_data,
  output logic       out_err,
  input  logic       out_ready,
  output logic [2:0] stg_sel,
  output logic [4:0] stg_in,
  output logic [4:0] stg_pos,
  input  logic [4:0] stg_out,
  output logic [4:0] pos_l,
  output logic [4:0] pos_m,
  output logic [4:0] pos_r
);

  // The left notch has no stepping effect; it is only range-checked here.
  if (NOTCH_R >= ALPHA || NOTCH_M >= ALPHA || NOTCH_L >= ALPHA) begin : g_notch_range
    $error("enigma_seq_ctrl: notch parameter outside alphabet");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_STAGE,
    S_DONE
  } state_t;

  state_t     state, state_nx;
  logic [2:0] idx;
  logic       bad_in;
  logic       r_at, m_at;

  function automatic logic [4:0] inc_mod(input logic [4:0] p);
    return (p == 5'(ALPHA - 1)) ? '0 : p + 5'd1;
  endfunction

  function automatic logic [4:0] wrap_cfg(input logic [4:0] p);
    return (p >= 5'(ALPHA)) ? p - 5'(ALPHA) : p;
  endfunction

  assign bad_in    = in_data > 5'(ALPHA - 1);
  assign r_at      = pos_r == 5'(NOTCH_R);
  assign m_at      = pos_m == 5'(NOTCH_M);
  assign in_ready  = (state == S_IDLE) && !cfg_load;
  assign out_valid = (state == S_DONE);
  assign stg_sel   = (state == S_STAGE) ? idx : '0;

  always_comb begin
    stg_pos = '0;
    unique case (stg_sel)
      3'd0, 3'd6: stg_pos = pos_r;
      3'd1, 3'd5: stg_pos = pos_m;
      3'd2, 3'd4: stg_pos = pos_l;
      default:    stg_pos = '0;
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (!cfg_load && in_valid) state_nx = bad_in ? S_DONE : S_STAGE;
      S_STAGE: if (idx == 3'd6) state_nx = S_DONE;
      S_DONE:  if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Stepping uses pre-step positions: both notch tests see the old values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_l    <= '0;
      pos_m    <= '0;
      pos_r    <= '0;
      stg_in   <= '0;
      idx      <= '0;
      out_data <= '0;
      out_err  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (cfg_load) begin
            pos_l <= wrap_cfg(cfg_pos_l);
            pos_m <= wrap_cfg(cfg_pos_m);
            pos_r <= wrap_cfg(cfg_pos_r);
          end else if (in_valid) begin
            if (bad_in) begin
              out_data <= in_data;
              out_err  <= 1'b1;
            end else begin
              pos_r  <= inc_mod(pos_r);
              if (r_at || m_at) pos_m <= inc_mod(pos_m);
              if (m_at) pos_l <= inc_mod(pos_l);
              stg_in <= in_data;
              idx    <= '0;
            end
          end
        end
        S_STAGE: begin
          stg_in <= stg_out;
          if (idx == 3'd6) begin
            out_data <= stg_out;
            out_err  <= 1'b0;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_enigma_seq_ctrl.sv
// Bench for enigma_seq_ctrl: identity rotors plus reflector B as the datapath,
// table vectors for the notch/wrap/error cases, random traffic against a model.
module tb_enigma_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_load;
  logic [4:0] cfg_pos_l, cfg_pos_m, cfg_pos_r;
  logic       in_valid;
  logic [4:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [4:0] out_data;
  logic       out_err;
  logic       out_ready;
  logic [2:0] stg_sel;
  logic [4:0] stg_in, stg_pos, stg_out;
  logic [4:0] pos_l, pos_m, pos_r;

  enigma_seq_ctrl #(.NOTCH_R(21), .NOTCH_M(4), .NOTCH_L(16), .ALPHA(26)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load),
    .cfg_pos_l(cfg_pos_l), .cfg_pos_m(cfg_pos_m), .cfg_pos_r(cfg_pos_r),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_err(out_err), .out_ready(out_ready),
    .stg_sel(stg_sel), .stg_in(stg_in), .stg_pos(stg_pos), .stg_out(stg_out),
    .pos_l(pos_l), .pos_m(pos_m), .pos_r(pos_r)
  );

  always #5 clk = ~clk;

  // Reflector B: YRUHQSLDPXNGOKMIEBFZCWVJAT
  int refl [26] = '{24, 17, 20, 7, 16, 18, 11, 3, 15, 23, 13, 6, 14,
                    10, 12, 8, 4, 1, 5, 25, 2, 22, 21, 9, 0, 19};

  always_comb begin
    stg_out = stg_in;
    if (stg_sel == 3'd3 && stg_in <= 5'd25) stg_out = 5'(refl[stg_in]);
  end

  int nvec = 0;
  int nerr = 0;
  int ml = 0, mm = 0, mr = 0;

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_pos(input int k);
    case (k)
      0, 6:    return mr;
      1, 5:    return mm;
      2, 4:    return ml;
      default: return 0;
    endcase
  endfunction

  // Reference stepping: right always turns; middle turns on right-at-V or
  // middle-at-E (double step); left turns only with middle-at-E.
  task automatic model_accept(input int letter);
    bit rn, mn;
    if (letter > 25) return;
    rn = (mr == 21);
    mn = (mm == 4);
    mr = (mr + 1) % 26;
    if (rn || mn) mm = (mm + 1) % 26;
    if (mn) ml = (ml + 1) % 26;
  endtask

  task automatic do_cfg(input int l, input int m, input int r);
    @(negedge clk);
    cfg_load = 1'b1;
    cfg_pos_l = 5'(l); cfg_pos_m = 5'(m); cfg_pos_r = 5'(r);
    #1 chk("in_ready_during_cfg", int'(in_ready), 0);
    @(negedge clk);
    cfg_load = 1'b0;
    ml = l % 26; mm = m % 26; mr = r % 26;
  endtask

  task automatic run_txn(input int letter, input int hold, output int d, output int e);
    int lat, stage_bad, hold_bad;
    @(negedge clk);
    chk("in_ready_idle", int'(in_ready), 1);
    in_valid = 1'b1;
    in_data  = 5'(letter);
    model_accept(letter);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    stage_bad = 0;
    while (!out_valid && lat < 20) begin
      if (int'(stg_sel) != lat - 1 || int'(stg_pos) != exp_pos(lat - 1)) stage_bad++;
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, (letter <= 25) ? 8 : 1);
    if (letter <= 25) chk("stage_seq", stage_bad, 0);
    d = int'(out_data);
    e = int'(out_err);
    hold_bad = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!out_valid || int'(out_data) != d || int'(out_err) != e || in_ready) hold_bad++;
    end
    if (hold > 0) chk("backpressure_hold", hold_bad, 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_released", int'(out_valid), 0);
    chk("in_ready_after_done", int'(in_ready), 1);
  endtask

  typedef struct {
    bit cfg;
    int cl, cm, cr;
    int letter, hold;
    int ed, ee, el, em, er;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int d, e, stale;

    tbl[0] = '{1, 0, 0, 0,   0, 0, 24, 0, 0, 0, 1};   // A -> Y
    tbl[1] = '{1, 0, 0, 21,  7, 0,  3, 0, 0, 1, 22};  // single notch
    tbl[2] = '{1, 0, 3, 21,  0, 1, 24, 0, 0, 4, 22};  // double step, 1st
    tbl[3] = '{0, 0, 0, 0,   1, 0, 17, 0, 1, 5, 23};  // double step, 2nd
    tbl[4] = '{1, 25, 4, 25, 2, 2, 20, 0, 0, 5, 0};   // wrap all three
    tbl[5] = '{0, 0, 0, 0,  27, 5, 27, 1, 0, 5, 0};   // invalid + backpressure
    tbl[6] = '{1, 30, 26, 31, 25, 0, 19, 0, 4, 0, 6}; // cfg values >25

    rst_n = 1'b0; cfg_load = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    cfg_pos_l = '0; cfg_pos_m = '0; cfg_pos_r = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_err", int'(out_err), 0);
    chk("rst_stg_sel", int'(stg_sel), 0);
    chk("rst_stg_in", int'(stg_in), 0);
    chk("rst_pos", {pos_l, pos_m, pos_r}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);

    for (int i = 0; i < 7; i++) begin
      if (tbl[i].cfg) do_cfg(tbl[i].cl, tbl[i].cm, tbl[i].cr);
      run_txn(tbl[i].letter, tbl[i].hold, d, e);
      chk($sformatf("tbl%0d_data", i), d, tbl[i].ed);
      chk($sformatf("tbl%0d_err", i), e, tbl[i].ee);
      chk($sformatf("tbl%0d_pos_l", i), int'(pos_l), tbl[i].el);
      chk($sformatf("tbl%0d_pos_m", i), int'(pos_m), tbl[i].em);
      chk($sformatf("tbl%0d_pos_r", i), int'(pos_r), tbl[i].er);
    end

    // Reset while the reflector stage is active.
    do_cfg(3, 4, 5);
    @(negedge clk);
    in_valid = 1'b1; in_data = 5'd10;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_at_stage3", int'(stg_sel), 3);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_pos", {pos_l, pos_m, pos_r}, 0);
    chk("midrst_stg_sel", int'(stg_sel), 0);
    @(negedge clk);
    rst_n = 1'b1;
    ml = 0; mm = 0; mr = 0;
    @(negedge clk);
    chk("midrst_in_ready", int'(in_ready), 1);
    stale = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("midrst_no_stale_out", stale, 0);

    for (int i = 0; i < 40; i++) begin
      int letter, hold, ed, ee;
      if ($urandom_range(3) == 0)
        do_cfg(int'($urandom_range(31)), int'($urandom_range(31)), int'($urandom_range(31)));
      else if ($urandom_range(4) == 0)
        do_cfg(int'($urandom_range(25)), 3 + int'($urandom_range(1)), 20 + int'($urandom_range(1)));
      letter = ($urandom_range(7) == 0) ? int'($urandom_range(31, 26)) : int'($urandom_range(25));
      hold = int'($urandom_range(3));
      ed = (letter <= 25) ? refl[letter] : letter;
      ee = (letter <= 25) ? 0 : 1;
      run_txn(letter, hold, d, e);
      chk("rnd_data", d, ed);
      chk("rnd_err", e, ee);
      chk("rnd_pos_l", int'(pos_l), ml);
      chk("rnd_pos_m", int'(pos_m), mm);
      chk("rnd_pos_r", int'(pos_r), mr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

endmodule
